circuit_response_compactor: RTL and testbench

CIRCUIT_RESPONSE_COMPACTOR -- requirements
Module: circuit_response_compactor

---
 rtl/circuit_response_compactor.sv | 100 ++++++++++
 tb/tb_circuit_response_compactor.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circuit_response_compactor.sv
// Exhaustive 2-input stimulus generator with an 18-bit MISR response compactor.
// Each run applies the four input vectors, compacts the circuit responses and compares the result against a golden signature.
module circuit_response_compactor #(
   parameter logic [17:0] SEED = 18'h00000,
   parameter logic [17:0] POLY = 18'h00081
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [17:0] expected_sig,
   output logic        x0,
   output logic        x1,
   input  logic [17:0] f,
   output logic        busy,
   output logic        done,
   output logic [17:0] signature,
   output logic        pass
);

   localparam int unsigned W  = 18;
   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [W-1:0]    misr, misr_n;
   logic [1:0]      x_q, x_n;
   logic            pass_n, busy_n, done_n;

   // Next-state and next-register values
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      misr_n  = misr;
      x_n     = x_q;
      pass_n  = pass;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_n   = '0;
               misr_n  = SEED;
               pass_n  = 1'b0;
               state_n = APPLY;
            end
         end
         APPLY: begin
            x_n     = cnt;
            state_n = SAMPLE;
         end
         SAMPLE: begin
            misr_n = {misr[W-2:0], 1'b0} ^ (misr[W-1] ? POLY : W'(0)) ^ f;
            if (cnt == CW'(3)) begin
               state_n = DONE;
            end else begin
               cnt_n   = cnt + CW'(1);
               state_n = APPLY;
            end
         end
         DONE: begin
            pass_n  = (misr == expected_sig);
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
   end

   // State and datapath registers; reset wins over any transition
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         misr  <= '0;
         x_q   <= '0;
         pass  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         misr  <= misr_n;
         x_q   <= x_n;
         pass  <= pass_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   assign x0        = x_q[0];
   assign x1        = x_q[1];
   assign signature = misr;

endmodule

// File: tb/tb_circuit_response_compactor.sv
// Directed bench for circuit_response_compactor: two instances (SEED 0 and SEED 18'h20000) run in lock-step
// against a software MISR model and a table-driven circuit under test.
module tb_circuit_response_compactor;

   typedef struct {
      logic [17:0] sig;
      logic        pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [17:0] expected_sig;
   logic [17:0] f;
   logic        x0, x1, busy, done, pass;
   logic [17:0] signature;
   logic        s_x0, s_x1, s_busy, s_done, s_pass;
   logic [17:0] s_signature;

   logic [17:0] cut_tab [4];
   exp_t        q0[$], q1[$];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   assign f = cut_tab[{x1, x0}];

   circuit_response_compactor dut (
      .clk(clk), .rst(rst), .start(start), .expected_sig(expected_sig),
      .x0(x0), .x1(x1), .f(f), .busy(busy), .done(done),
      .signature(signature), .pass(pass)
   );

   circuit_response_compactor #(.SEED(18'h20000), .POLY(18'h00081)) dut_s (
      .clk(clk), .rst(rst), .start(start), .expected_sig(expected_sig),
      .x0(s_x0), .x1(s_x1), .f(f), .busy(s_busy), .done(s_done),
      .signature(s_signature), .pass(s_pass)
   );

   function automatic logic [17:0] model_run(input logic [17:0] seed);
      logic [17:0] m;
      m = seed;
      for (int v = 0; v < 4; v++)
         m = {m[16:0], 1'b0} ^ (m[17] ? 18'h00081 : 18'h00000) ^ cut_tab[v];
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      exp_t e;
      e.sig  = model_run(18'h00000);
      e.pass = (e.sig == expected_sig);
      q0.push_back(e);
      e.sig  = model_run(18'h20000);
      e.pass = (e.sig == expected_sig);
      q1.push_back(e);
   endtask

   // Raises start (held for hold extra cycles), watches ncyc cycles; returns done cycles and captured results
   task automatic run_plain(input int hold, input int ncyc, output int done_k, output int done_k2,
                            output int n_done, output logic [17:0] sig0, output logic [17:0] sig1,
                            output logic p0, output logic p1);
      done_k = -1; done_k2 = -1; n_done = 0;
      sig0 = 'x; sig1 = 'x; p0 = 1'bx; p1 = 1'bx;
      start = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         tick();
         if (k > hold) start = 1'b0;
         if (k == done_k + 1 && done_k > 0) begin
            p0 = pass;
            p1 = s_pass;
         end
         if (done) begin
            n_done++;
            if (done_k < 0) begin
               done_k = k;
               sig0 = signature;
               sig1 = s_signature;
            end else begin
               done_k2 = k;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string name, input int done_k, input logic [17:0] sig0,
                            input logic [17:0] sig1, input logic p0, input logic p1);
      exp_t e0, e1;
      vectors++;
      if (q0.size() == 0 || q1.size() == 0) begin
         miscompares++;
         $display("FAIL %s scoreboard: empty queue", name);
         return;
      end
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      if (done_k !== 9) begin
         miscompares++;
         $display("FAIL %s latency: done at %0d, required 9", name, done_k);
      end
      vectors++;
      if (sig0 !== e0.sig) begin
         miscompares++;
         $display("FAIL %s sig seed0: got %h, required %h", name, sig0, e0.sig);
      end
      vectors++;
      if (sig1 !== e1.sig) begin
         miscompares++;
         $display("FAIL %s sig seed20000: got %h, required %h", name, sig1, e1.sig);
      end
      vectors++;
      if (p0 !== e0.pass) begin
         miscompares++;
         $display("FAIL %s pass seed0: got %b, required %b", name, p0, e0.pass);
      end
      vectors++;
      if (p1 !== e1.pass) begin
         miscompares++;
         $display("FAIL %s pass seed20000: got %b, required %b", name, p1, e1.pass);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; expected_sig = '0;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'h3ffff;
      tick(); tick();
      vectors++;
      if ({busy, done, pass, x1, x0, signature, s_busy, s_signature} !== '0) begin
         miscompares++;
         $display("FAIL reset: busy=%b done=%b pass=%b x=%b%b sig=%h s_sig=%h, required all 0",
                  busy, done, pass, x1, x0, signature, s_signature);
      end
      rst = 1'b0; start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_priority: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_order();
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'(v * 18'h01111 + 18'h00005);
      expected_sig = model_run(18'h00000);
      push_expected();
      start = 1'b1;
      begin
         int done_k = -1; int n_done = 0;
         logic [17:0] sig0, sig1;
         logic p0, p1;
         for (int k = 1; k <= 12; k++) begin
            tick();
            start = 1'b0;
            if (k % 2 == 0 && k <= 8) begin
               vectors++;
               if ({x1, x0} !== 2'(k / 2 - 1)) begin
                  miscompares++;
                  $display("FAIL order k=%0d: {x1,x0}=%b, required %b", k, {x1, x0}, 2'(k / 2 - 1));
               end
            end
            if (k <= 9 && busy !== 1'b1) begin
               vectors++; miscompares++;
               $display("FAIL busy k=%0d: got %b, required 1", k, busy);
            end
            if (k == 10) begin
               vectors++;
               if (busy !== 1'b0) begin
                  miscompares++;
                  $display("FAIL busy_end: got %b, required 0", busy);
               end
               p0 = pass; p1 = s_pass;
            end
            if (k == 12) begin
               vectors++;
               if ({x1, x0, signature} !== {2'b11, sig0}) begin
                  miscompares++;
                  $display("FAIL idle_hold: x=%b sig=%h, required x=11 sig=%h", {x1, x0}, signature, sig0);
               end
            end
            if (done) begin
               n_done++;
               done_k = k; sig0 = signature; sig1 = s_signature;
            end
         end
         vectors++;
         if (n_done !== 1) begin
            miscompares++;
            $display("FAIL order_done_count: got %0d, required 1", n_done);
         end
         check_run("order", done_k, sig0, sig1, p0, p1);
      end
   endtask

   task automatic test_constant();
      int dk, dk2, nd; logic [17:0] s0, s1; logic p0, p1;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'h00001;
      expected_sig = 18'h0000F;
      push_expected();
      run_plain(0, 11, dk, dk2, nd, s0, s1, p0, p1);
      check_run("constant", dk, s0, s1, p0, p1);
      vectors++;
      if (s0 !== 18'h0000F || p0 !== 1'b1) begin
         miscompares++;
         $display("FAIL constant_abs: sig=%h pass=%b, required 0000f/1", s0, p0);
      end
   endtask

   task automatic test_feedback();
      int dk, dk2, nd; logic [17:0] s0, s1; logic p0, p1;
      logic [17:0] steps [4];
      steps[0] = 18'h00081; steps[1] = 18'h00102; steps[2] = 18'h00204; steps[3] = 18'h00408;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'h00000;
      expected_sig = 18'h00408;
      push_expected();
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         start = 1'b0;
         if (k % 2 == 1 && k >= 3) begin
            vectors++;
            if (s_signature !== steps[(k - 3) / 2]) begin
               miscompares++;
               $display("FAIL feedback_step k=%0d: got %h, required %h", k, s_signature, steps[(k - 3) / 2]);
            end
         end
         if (done) begin dk = k; s0 = signature; s1 = s_signature; end
         if (k == 10) begin p0 = pass; p1 = s_pass; end
      end
      check_run("feedback_match", dk, s0, s1, p0, p1);
      expected_sig = 18'h00409;
      push_expected();
      run_plain(0, 11, dk, dk2, nd, s0, s1, p0, p1);
      check_run("feedback_miss", dk, s0, s1, p0, p1);
   endtask

   task automatic test_mismatch();
      int dk, dk2, nd; logic [17:0] s0, s1; logic p0, p1;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'h00000;
      expected_sig = 18'h00001;
      push_expected();
      run_plain(0, 14, dk, dk2, nd, s0, s1, p0, p1);
      check_run("mismatch", dk, s0, s1, p0, p1);
      vectors++;
      if (nd !== 1) begin
         miscompares++;
         $display("FAIL mismatch_done_count: got %0d, required 1", nd);
      end
   endtask

   task automatic test_abort();
      int dk, dk2, nd; logic [17:0] s0, s1; logic p0, p1;
      int n_done = 0;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'($urandom);
      expected_sig = model_run(18'h20000);
      start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         start = 1'b0;
         if (done) n_done++;
         if (k == 4) rst = 1'b1;
         if (k == 5) begin
            rst = 1'b0;
            vectors++;
            if ({busy, done, pass, x1, x0, signature, s_signature} !== '0) begin
               miscompares++;
               $display("FAIL abort_clear: busy=%b done=%b pass=%b x=%b%b sig=%h s_sig=%h, required all 0",
                        busy, done, pass, x1, x0, signature, s_signature);
            end
         end
      end
      vectors++;
      if (n_done !== 0) begin
         miscompares++;
         $display("FAIL abort_no_done: got %0d pulses, required 0", n_done);
      end
      push_expected();
      run_plain(0, 11, dk, dk2, nd, s0, s1, p0, p1);
      check_run("after_abort", dk, s0, s1, p0, p1);
   endtask

   task automatic test_back_to_back();
      int dk, dk2, nd; logic [17:0] s0, s1; logic p0, p1;
      for (int v = 0; v < 4; v++) cut_tab[v] = 18'($urandom);
      expected_sig = model_run(18'h00000);
      push_expected();
      push_expected();
      // start high through DONE and into IDLE: only the IDLE cycle starts the second run
      run_plain(10, 24, dk, dk2, nd, s0, s1, p0, p1);
      check_run("held_start", dk, s0, s1, p0, p1);
      vectors++;
      if (nd !== 2 || dk2 !== 19) begin
         miscompares++;
         $display("FAIL held_start_runs: %0d dones, second at %0d, required 2 and 19", nd, dk2);
      end
      vectors++;
      if (signature !== q0[0].sig) begin
         miscompares++;
         $display("FAIL held_start_sig2: got %h, required %h", signature, q0[0].sig);
      end
      q0.delete(); q1.delete();
   endtask

   initial begin
      test_reset();
      test_order();
      test_constant();
      test_feedback();
      test_mismatch();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
